// File: rtl/data_mem_master_if.sv
// data_mem_master_if: request/response channels plus the data_memory bus.
// master = controller side, slave = pipeline + memory side.
interface data_mem_master_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       data_out;

  modport master (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  rsp_ready, data_out,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_error, address, write_data,
    output mem_write, mem_read
  );

  modport slave (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output rsp_ready, data_out,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_error, address, write_data,
    input  mem_write, mem_read
  );
endinterface

// File: rtl/data_mem_master.sv
// data_mem_master: sequences byte-addressed loads/stores onto data_memory.
// Define SUBWORD_EN for byte/half accesses (stores via read-modify-write).
module data_mem_master #(
  parameter int ADDR_W       = 7,
  parameter int READ_LATENCY = 1
) (
  input logic               clock,
  input logic               reset_n,
  data_mem_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, CHECK, RD, WR, RSP
  } state_t;

  localparam logic [1:0] LAST = 2'(READ_LATENCY);

  state_t            state;
  logic [1:0]        cnt;
  logic              wr;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              err;
  logic              word_st;
  logic [ADDR_W-1:0] waddr;

  assign waddr   = addr[ADDR_W+1:2];
  assign word_st = wr && (size == 2'd2);

  always_comb begin
    err = (size == 2'd3)
       || (size == 2'd1 && addr[0])
       || (size == 2'd2 && addr[1:0] != 2'b00)
       || (addr[31:ADDR_W+2] != '0);
`ifndef SUBWORD_EN
    err = err || (size != 2'd2);
`endif
  end

`ifdef SUBWORD_EN
  logic sgn;

  function automatic logic [31:0] fmt(
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {addr[1:0], 3'b000});
    h = 16'(w >> {addr[1], 4'b0000});
    unique case (size)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Only the addressed lane is replaced.
  function automatic logic [31:0] merge(
    input logic [31:0] w
  );
    logic [31:0] m;
    logic [31:0] d;
    if (size == 2'd0) begin
      m = 32'h0000_00ff << {addr[1:0], 3'b000};
      d = {4{wdata[7:0]}};
    end else begin
      m = 32'h0000_ffff << {addr[1], 4'b0000};
      d = {2{wdata[15:0]}};
    end
    return (w & ~m) | (d & m);
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      wr             <= 1'b0;
      size           <= '0;
      addr           <= '0;
      wdata          <= '0;
`ifdef SUBWORD_EN
      sgn            <= 1'b0;
`endif
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_error  <= 1'b0;
      bus.address    <= '0;
      bus.write_data <= '0;
      bus.mem_write  <= 1'b0;
      bus.mem_read   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            wr            <= bus.req_write;
            size          <= bus.req_size;
            addr          <= bus.req_addr;
            wdata         <= bus.req_wdata;
`ifdef SUBWORD_EN
            sgn           <= bus.req_signed;
`endif
            bus.req_ready <= 1'b0;
            state         <= CHECK;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        CHECK: begin
          cnt <= '0;
          unique case (1'b1)
            err: begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_error <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= RSP;
            end
            (!err && word_st): begin
              bus.mem_write  <= 1'b1;
              bus.address    <= waddr;
              bus.write_data <= wdata;
              state          <= WR;
            end
            (!err && !word_st): begin
              bus.mem_read <= 1'b1;
              bus.address  <= waddr;
              state        <= RD;
            end
          endcase
        end
        RD: begin
          if (cnt == LAST) begin
            bus.mem_read <= 1'b0;
`ifdef SUBWORD_EN
            if (wr) begin
              bus.mem_write  <= 1'b1;
              bus.write_data <= merge(bus.data_out);
              state          <= WR;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= fmt(bus.data_out);
              state         <= RSP;
            end
`else
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.data_out;
            state         <= RSP;
`endif
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WR: begin
          bus.mem_write <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_error <= 1'b0;
          bus.rsp_rdata <= '0;
          state         <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_master.sv
// tb_data_mem_master: random loads/stores against a byte-level memory model.
// Also pins the model with hand-computed cases, stalls and a mid-read reset.
module tb_data_mem_master;
  localparam int AW  = 7;
  localparam int LAT = 1;
  localparam int NW  = 1 << AW;
  localparam int NB  = 4 * NW;
`ifdef SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          reads;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  exp_t q[$];

  data_mem_master_if #(.ADDR_W(AW)) bus ();

  data_mem_master #(
    .ADDR_W(AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // data_memory stand-in: write on the edge, read data LAT cycles later
  logic [31:0]   mem [NW];
  logic [31:0]   pipe [4];
  logic          init_we = 1'b0;
  logic [AW-1:0] init_a  = '0;
  logic [31:0]   init_d  = '0;
  logic [7:0]    ref_b [NB];

  always @(posedge clock) begin
    if (init_we) mem[init_a] <= init_d;
    else if (bus.mem_write) mem[bus.address] <= bus.write_data;
    pipe[0] <= mem[bus.address];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.data_out = (LAT == 0) ? mem[bus.address]
                                   : pipe[(LAT == 0) ? 0 : LAT - 1];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: what a request must do and when it answers.
  task automatic model(input bit w, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int n;
    int base;
    logic [31:0] v;
    n = (sz == 2'd3) ? 4 : (1 << sz);
    e.rdata  = '0;
    e.reads  = 0;
    e.writes = 0;
    e.wdata  = '0;
    e.waddr  = a / 4;
    e.err = (sz == 2'd3) || (a % n != 0) || (a >= NB)
         || (!SUB && sz != 2'd2);
    if (e.err) begin
      e.cyc = 2;
    end else if (w) begin
      for (int b = 0; b < n; b++) ref_b[a+b] = wd[8*b +: 8];
      base    = int'(a / 4) * 4;
      e.wdata = {ref_b[base+3], ref_b[base+2],
                 ref_b[base+1], ref_b[base]};
      e.writes = 1;
      e.reads  = (n == 4) ? 0 : LAT + 1;
      e.cyc    = (n == 4) ? 3 : 4 + LAT;
    end else begin
      v = '0;
      for (int b = 0; b < n; b++) v |= 32'(ref_b[a+b]) << (8*b);
      if (sg && n < 4 && v[8*n-1]) v |= 32'hffff_ffff << (8*n);
      e.rdata = v;
      e.reads = LAT + 1;
      e.cyc   = 3 + LAT;
    end
  endtask

  task automatic accept(input bit w, input logic [1:0] sz,
                        input bit sg, input logic [31:0] a,
                        input logic [31:0] wd);
    int g = 0;
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    while (!bus.req_ready && g < 50) begin
      @(posedge clock); #1;
      g++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 1);
    acc_cyc = cyc;
    model(w, sz, sg, a, wd, e);
    e.cyc = acc_cyc + e.cyc;
    q.push_back(e);
    @(posedge clock); #1;
    // junk on the request port while busy must be ignored
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_write  = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic finish_rsp(input int stall, output logic [31:0] rd,
                            output logic er, output int rel);
    int g = 0;
    bit seen = 0;
    bit done = 0;
    rd  = '0;
    er  = 1'b0;
    rel = -1;
    while (!done && g < 60) begin
      if (bus.rsp_valid && !seen) begin
        seen = 1;
        rel  = cyc - acc_cyc;
        rd   = bus.rsp_rdata;
        er   = bus.rsp_error;
      end
      if (bus.rsp_valid && stall > 0) begin
        bus.rsp_ready = 1'b0;
        stall--;
      end else begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        done = 1;
        bus.req_valid = 1'b0;
      end
      @(posedge clock); #1;
      g++;
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    if (!done) chk("rsp_timeout", 32'(done), 1);
  endtask

  task automatic issue(input bit w, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er,
                       output int rel);
    accept(w, sz, sg, a, wd);
    finish_rsp(stall, rd, er, rel);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({nm, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({nm, "_rsp_error"}, 32'(bus.rsp_error), 0);
    chk({nm, "_address"}, 32'(bus.address), 0);
    chk({nm, "_write_data"}, bus.write_data, 0);
    chk({nm, "_mem_write"}, 32'(bus.mem_write), 0);
    chk({nm, "_mem_read"}, 32'(bus.mem_read), 0);
  endtask

  // Cycle-by-cycle compare of the DUT against the queued expectations
  initial begin : monitor
    exp_t cur;
    bit active = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        q.delete();
        active = 0;
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        chk("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 0);
        if (bus.mem_read || bus.mem_write) begin
          if (q.size() == 0) begin
            chk("mem_idle", 32'({bus.mem_read, bus.mem_write}), 0);
          end else begin
            chk("mem_addr", 32'(bus.address), q[0].waddr);
            if (bus.mem_read) rd_cnt++;
            if (bus.mem_write) begin
              wr_cnt++;
              chk("mem_wdata", bus.write_data, q[0].wdata);
            end
          end
        end
        if (active && !bus.rsp_valid) chk("rsp_hold", 32'(bus.rsp_valid), 1);
        if (bus.rsp_valid) begin
          if (!active) begin
            if (q.size() == 0) begin
              chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
            end else begin
              cur    = q.pop_front();
              active = 1;
              chk("rsp_cycle", cyc, cur.cyc);
              chk("rd_cycles", rd_cnt, cur.reads);
              chk("wr_cycles", wr_cnt, cur.writes);
              rd_cnt = 0;
              wr_cnt = 0;
            end
          end
          if (active) begin
            chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
            chk("rsp_error", 32'(bus.rsp_error), 32'(cur.err));
            chk("req_ready_busy", 32'(bus.req_ready), 0);
            if (bus.rsp_ready) active = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          rel;
    logic [31:0] d;
    bit          w;
    logic [1:0]  sz;
    logic [31:0] a;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk_idle_outputs("reset");

    init_we = 1'b1;
    for (int i = 0; i < NW; i++) begin
      init_a = AW'(i);
      init_d = $urandom;
      {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]} = init_d;
      @(posedge clock); #1;
    end
    init_we = 1'b0;
    reset_n = 1'b1;
    chk("ready_in_reset", 32'(bus.req_ready), 0);
    @(posedge clock); #1;
    chk("ready_after_reset", 32'(bus.req_ready), 1);

    // Word store then word load of 0x190 (word 100)
    issue(1, 2'd2, 0, 32'h190, 32'd3, 0, rd, er, rel);
    chk("st_mem100", mem[100], 32'd3);
    chk("st_lat", rel, 3);
    chk("st_err", 32'(er), 0);
    issue(0, 2'd2, 0, 32'h190, 32'd0, 0, rd, er, rel);
    chk("ld_rdata", rd, 32'd3);
    chk("ld_err", 32'(er), 0);
    chk("ld_lat", rel, 4);

`ifdef SUBWORD_EN
    issue(1, 2'd2, 0, 32'h190, 32'h1122_3344, 0, rd, er, rel);
    issue(1, 2'd0, 0, 32'h192, 32'h0000_00aa, 0, rd, er, rel);
    chk("sb_lat", rel, 4 + LAT);
    chk("sb_mem100", mem[100], 32'h11aa_3344);
    issue(0, 2'd0, 1, 32'h192, 32'd0, 0, rd, er, rel);
    chk("lb_signed", rd, 32'hffff_ffaa);
    issue(0, 2'd1, 0, 32'h192, 32'd0, 0, rd, er, rel);
    chk("lhu", rd, 32'h0000_11aa);
`else
    issue(0, 2'd1, 0, 32'h10, 32'd0, 0, rd, er, rel);
    chk("half_err", 32'(er), 1);
    chk("half_lat", rel, 2);
`endif

    // Error cases
    issue(0, 2'd2, 0, 32'h191, 32'd0, 0, rd, er, rel);
    chk("misalign_err", 32'(er), 1);
    chk("misalign_lat", rel, 2);
    chk("misalign_rdata", rd, 0);
    issue(0, 2'd2, 0, 32'h200, 32'd0, 0, rd, er, rel);
    chk("range_err", 32'(er), 1);
    issue(0, 2'd3, 0, 32'h0, 32'd0, 0, rd, er, rel);
    chk("size3_err", 32'(er), 1);

    // Consumer stalls for 5 cycles
    issue(0, 2'd2, 0, 32'h190, 32'd0, 5, rd, er, rel);
    chk("stall_rdata", rd, {ref_b[403], ref_b[402], ref_b[401], ref_b[400]});

    // Reset while in RD: no response, everything cleared
    accept(0, 2'd2, 0, 32'h190, 32'd0);
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rd_before_abort", 32'(bus.mem_read), 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk_idle_outputs("abort");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("abort_ready", 32'(bus.req_ready), 1);
    chk("abort_no_rsp", 32'(bus.rsp_valid), 0);
    d = $urandom;
    issue(1, 2'd2, 0, 32'h14, d, 0, rd, er, rel);
    chk("post_abort_mem5", mem[5], d);
    chk("post_abort_err", 32'(er), 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
      else a = 32'($urandom_range(0, NB - 1));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0)
        a = a & ~((32'd1 << sz) - 32'd1);
      issue(w, sz, 1'($urandom), a, $urandom,
            $urandom_range(0, 3), rd, er, rel);
    end

    for (int i = 0; i < NW; i++)
      chk("final_mem", mem[i],
          {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_master.md
# data_mem_master

Request-side controller for the single-port `data_memory` block. It is the initiator that drives `address`, `write_data`, `mem_write` and `mem_read`. It accepts byte-addressed load/store requests from the pipeline over a valid/ready handshake and sequences the word-addressed memory, respecting its read latency. It returns load data and per-access error status over a valid/ready response channel. With `SUBWORD_EN`, byte and halfword stores are performed by read-modify-write.

## Interface
- `ADDR_W`, 7: memory word-address width (128 words).
- `READ_LATENCY`, 1: cycles from the `mem_read` cycle until `data_out` is valid. Legal values are 0..3.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller idle and able to accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_signed` input 1: sign-extend sub-word loads.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, LSB-aligned.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumer ready.
- `rsp_rdata` output 32: load result, LSB-aligned and extended; 0 for stores and errors.
- `rsp_error` output 1: misaligned, out-of-range, or illegal/unsupported size.
- `address` output ADDR_W: memory word address.
- `write_data` output 32: memory write data.
- `mem_write` output 1: memory write strobe; the memory writes on the edge ending the cycle.
- `mem_read` output 1: memory read enable.
- `data_out` input 32: memory read data.

## Operation
- FSM states: IDLE, CHECK, RD, WR, RSP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch the request and go to CHECK.
- CHECK (1 cycle): the request is an error if any of the following holds.
  - `req_size`==3.
  - half with `addr[0]`=1.
  - word with `addr[1:0]`≠0.
  - `addr[31:ADDR_W+2]`≠0.
  - Without `SUBWORD_EN`, any `req_size`≠2.
- CHECK transitions:
  - Error: go to RSP with `rsp_error`=1; the memory is not accessed.
  - Word store: go to WR.
  - Any load, or a sub-word store: go to RD.
- RD
  - `mem_read`=1 and `address`=`addr[ADDR_W+1:2]` for READ_LATENCY+1 cycles.
  - `data_out` is captured on the edge ending the last RD cycle.
  - Loads then go to RSP. Sub-word stores go to WR.
- Load formatting: lane = `addr[1:0]` (byte) or `addr[1]` (half). The selected lane is zero-extended, or sign-extended when `req_signed`=1.
- WR
  - `mem_write`=1 for exactly 1 cycle.
  - Word store: `write_data`=`req_wdata`.
  - Sub-word store: `write_data` = the captured word with the addressed lane replaced by `req_wdata[7:0]` or `req_wdata[15:0]`.
  - Then go to RSP.
- RSP
  - `rsp_valid`=1; `rsp_rdata` and `rsp_error` are held stable until `rsp_valid`&&`rsp_ready`.
  - Then go to IDLE; `req_ready`=1 in the next cycle.
- `mem_read` and `mem_write` are never high in the same cycle. Both are 0 outside RD and WR.

## Timing
- Reset: every output is 0, including `req_ready`, which is registered. The state becomes IDLE. `req_ready` rises in the cycle after the first edge with `reset_n`=1.
- Word store, accepted in cycle 0: CHECK in cycle 1, WR in cycle 2, `rsp_valid` in cycle 3.
- Load, accepted in cycle 0: CHECK in cycle 1, RD in cycles 2..2+READ_LATENCY, `rsp_valid` in cycle 3+READ_LATENCY.
- Sub-word store: `rsp_valid` in cycle 4+READ_LATENCY.
- Error: `rsp_valid` in cycle 2.
- Throughput: at most one outstanding request. Back-to-back requests are spaced by the full latency plus 1 idle cycle.
- `rsp_ready` held 0: the FSM stalls in RSP indefinitely and outputs stay stable.
- Reset asserted mid-operation: the operation is aborted and no response is issued. If the reset edge ends a WR cycle, that memory write still takes effect, because `mem_write` was high during the cycle.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `SUBWORD_EN` defined: byte and half accesses are supported; stores use read-modify-write.
- `SUBWORD_EN` undefined:
  - Only word accesses are supported; byte/half requests complete with `rsp_error`=1 and no memory access.
  - The RD→WR path and lane-merge logic are absent.
  - The `req_signed` input is ignored.

## Test plan
- After reset, word store `addr`=0x190, `wdata`=3 → `mem_write` for one cycle with `address`=100 and `write_data`=3. Then word load of 0x190 → `rsp_rdata`=3, `rsp_error`=0, `rsp_valid` in cycle 4 (READ_LATENCY=1).
- With `SUBWORD_EN`: word 100 = 0x11223344; byte store 0xAA to 0x192 → memory word becomes 0x11AA3344. Then a signed byte load of 0x192 → `rsp_rdata`=0xFFFFFFAA.
- Error cases:
  - Word load at 0x191 → `rsp_error`=1 in cycle 2, with no `mem_read`.
  - Load at 0x200 → `rsp_error`=1.
  - `req_size`=3 → `rsp_error`=1.
- Hold `rsp_ready`=0 for 5 cycles on a load → `rsp_valid` and `rsp_rdata` stable, `req_ready`=0 throughout.
- Drive `reset_n`=0 during RD → no response, all outputs 0. A following store to word 5 completes normally.
- Without `SUBWORD_EN`: half load at 0x10 → `rsp_error`=1, no memory access.
